// File: rtl/rvfpm_issue_queue.sv
// In-order issue queue between the CV-X-IF issue/commit interfaces and the rvfpm
// execute stage. Only committed head entries are presented; killed entries drain silently.
module rvfpm_issue_queue #(
  parameter int DEPTH       = 4,
  parameter int X_ID_WIDTH  = 4,
  parameter int X_NUM_RS    = 3,
  parameter int X_RFR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  logic                            issue_accept,
  input  logic [31:0]                     issue_instr,
  input  logic [1:0]                      issue_mode,
  input  logic [X_ID_WIDTH-1:0]           issue_id,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs,
  input  logic [X_NUM_RS-1:0]             issue_rs_valid,
  input  logic                            commit_valid,
  input  logic [X_ID_WIDTH-1:0]           commit_id,
  input  logic                            commit_kill,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_instr,
  output logic [1:0]                      out_mode,
  output logic [X_ID_WIDTH-1:0]           out_id,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0] out_rs,
  output logic [X_NUM_RS-1:0]             out_rs_valid,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            commit_miss
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RSW = X_NUM_RS * X_RFR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_KILL   = 2'd3
  } ent_state_t;

  ent_state_t              ent_state    [DEPTH];
  logic [31:0]             ent_instr    [DEPTH];
  logic [1:0]              ent_mode     [DEPTH];
  logic [X_ID_WIDTH-1:0]   ent_id       [DEPTH];
  logic [RSW-1:0]          ent_rs       [DEPTH];
  logic [X_NUM_RS-1:0]     ent_rs_valid [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          enq;
  logic          pop;
  logic          drop;
  logic          deq;
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          enq_hit;
  ent_state_t    enq_state;
  ent_state_t    commit_state;

  assign issue_ready  = (count < DEPTH_C);
  assign enq          = issue_valid & issue_ready & issue_accept;

  // Freed slots return to ST_FREE, so the head state alone tells empty/pending/killed.
  assign out_valid    = (ent_state[rd_ptr] == ST_COMMIT);
  assign drop         = (ent_state[rd_ptr] == ST_KILL);
  assign pop          = out_valid & out_ready;
  assign deq          = pop | drop;

  assign out_instr    = ent_instr[rd_ptr];
  assign out_mode     = ent_mode[rd_ptr];
  assign out_id       = ent_id[rd_ptr];
  assign out_rs       = ent_rs[rd_ptr];
  assign out_rs_valid = ent_rs_valid[rd_ptr];

  assign commit_state = commit_kill ? ST_KILL : ST_COMMIT;

  // Scan from the head so the oldest pending entry with a matching id wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && ent_state[rd_ptr + PW'(i)] == ST_PEND &&
          ent_id[rd_ptr + PW'(i)] == commit_id) begin
        hit     = 1'b1;
        hit_idx = rd_ptr + PW'(i);
      end
    end
  end

  always_comb begin
    enq_hit   = commit_valid & ~hit & enq & (commit_id == issue_id);
    enq_state = enq_hit ? commit_state : ST_PEND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_state[i]    <= ST_FREE;
        ent_instr[i]    <= '0;
        ent_mode[i]     <= '0;
        ent_id[i]       <= '0;
        ent_rs[i]       <= '0;
        ent_rs_valid[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      commit_miss <= 1'b0;
    end else begin
      // Commit, dequeue and enqueue always address distinct slots in the same cycle.
      if (commit_valid && hit) begin
        ent_state[hit_idx] <= commit_state;
      end
      if (deq) begin
        ent_state[rd_ptr] <= ST_FREE;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (enq) begin
        ent_state[wr_ptr]    <= enq_state;
        ent_instr[wr_ptr]    <= issue_instr;
        ent_mode[wr_ptr]     <= issue_mode;
        ent_id[wr_ptr]       <= issue_id;
        ent_rs[wr_ptr]       <= issue_rs;
        ent_rs_valid[wr_ptr] <= issue_rs_valid;
        wr_ptr               <= wr_ptr + 1'b1;
      end
      count       <= count + CW'(enq) - CW'(deq);
      commit_miss <= commit_valid & ~hit & ~enq_hit;
    end
  end

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// Directed bench for rvfpm_issue_queue: scoreboard of expected head deliveries
// plus cycle-level checks of flags, latency, miss pulse and reset behaviour.
module tb_rvfpm_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic        issue_accept = 1'b1;
  logic [31:0] issue_instr = '0;
  logic [1:0]  issue_mode = '0;
  logic [3:0]  issue_id = '0;
  logic [95:0] issue_rs = '0;
  logic [2:0]  issue_rs_valid = '0;
  logic        commit_valid = 1'b0;
  logic [3:0]  commit_id = '0;
  logic        commit_kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [1:0]  out_mode;
  logic [3:0]  out_id;
  logic [95:0] out_rs;
  logic [2:0]  out_rs_valid;
  logic [2:0]  count;
  logic        commit_miss;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] instr;
    logic [1:0]  mode;
    logic [95:0] rs;
    logic [2:0]  rsv;
  } exp_t;

  exp_t sb[$];

  rvfpm_issue_queue #(.DEPTH(4), .X_ID_WIDTH(4), .X_NUM_RS(3), .X_RFR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_accept(issue_accept),
    .issue_instr(issue_instr), .issue_mode(issue_mode), .issue_id(issue_id),
    .issue_rs(issue_rs), .issue_rs_valid(issue_rs_valid),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_mode(out_mode), .out_id(out_id), .out_rs(out_rs), .out_rs_valid(out_rs_valid),
    .count(count), .commit_miss(commit_miss)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [3:0] id);
    return (id == 4'd1) ? 32'h00B5_0553 : (32'h1000_0053 + (32'(id) << 15));
  endfunction

  function automatic logic [1:0] mode_of(input logic [3:0] id);
    return id[1:0];
  endfunction

  function automatic logic [95:0] rs_of(input logic [3:0] id);
    return {32'hC0DE_0000 | 32'(id), 32'hB0B0_0000 | 32'(id), 32'hA5A5_0000 | 32'(id)};
  endfunction

  function automatic logic [2:0] rsv_of(input logic [3:0] id);
    return id[2:0] ^ 3'b101;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [3:0] id);
    issue_valid    = 1'b1;
    issue_id       = id;
    issue_instr    = instr_of(id);
    issue_mode     = mode_of(id);
    issue_rs       = rs_of(id);
    issue_rs_valid = rsv_of(id);
  endtask

  task automatic drive_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  task automatic push_exp(input logic [3:0] id);
    exp_t e;
    e.id    = id;
    e.instr = instr_of(id);
    e.mode  = mode_of(id);
    e.rs    = rs_of(id);
    e.rsv   = rsv_of(id);
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (count != 3'd0 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 128'(count), 128'd0);
  endtask

  // Every accepted head transfer is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out observed id=%0h expected no output", out_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_id", 128'(out_id), 128'(e.id));
        chk("sb_instr", 128'(out_instr), 128'(e.instr));
        chk("sb_mode", 128'(out_mode), 128'(e.mode));
        chk("sb_rs", 128'(out_rs), 128'(e.rs));
        chk("sb_rs_valid", 128'(out_rs_valid), 128'(e.rsv));
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_ready", 128'(issue_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_miss", 128'(commit_miss), 128'd0);
    chk("rst_out_instr", 128'(out_instr), 128'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic enqueue, commit next cycle, deliver two cycles after issue.
    out_ready = 1'b1;
    drive_issue(4'd1);
    step();
    issue_valid = 1'b0;
    chk("t1_count_after_enq", 128'(count), 128'd1);
    chk("t1_pending_not_valid", 128'(out_valid), 128'd0);
    drive_commit(4'd1, 1'b0);
    push_exp(4'd1);
    step();
    commit_valid = 1'b0;
    chk("t1_out_valid", 128'(out_valid), 128'd1);
    chk("t1_out_id", 128'(out_id), 128'd1);
    chk("t1_out_instr", 128'(out_instr), 128'h00B5_0553);
    step();
    chk("t1_count_done", 128'(count), 128'd0);

    // Fill to DEPTH without commits; a fifth issue must be refused.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(4'(i));
      step();
    end
    chk("t2_count_full", 128'(count), 128'd4);
    chk("t2_ready_full", 128'(issue_ready), 128'd0);
    chk("t2_out_valid", 128'(out_valid), 128'd0);
    drive_issue(4'd8);
    step();
    issue_valid = 1'b0;
    chk("t2_fifth_refused", 128'(count), 128'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_commit(4'(i), 1'b0);
      push_exp(4'(i));
      step();
    end
    commit_valid = 1'b0;
    drain("t2_drained");

    // Kill the oldest of three; the survivors appear in order after one bubble.
    for (int i = 2; i < 5; i++) begin
      drive_issue(4'(i));
      step();
    end
    issue_valid = 1'b0;
    drive_commit(4'd2, 1'b1);
    step();
    chk("t3_bubble", 128'(out_valid), 128'd0);
    chk("t3_count_before_drop", 128'(count), 128'd3);
    drive_commit(4'd3, 1'b0);
    push_exp(4'd3);
    step();
    chk("t3_first_valid", 128'(out_valid), 128'd1);
    chk("t3_first_id", 128'(out_id), 128'd3);
    drive_commit(4'd4, 1'b0);
    push_exp(4'd4);
    step();
    commit_valid = 1'b0;
    chk("t3_second_id", 128'(out_id), 128'd4);
    drain("t3_drained");

    // Commit of an absent id pulses commit_miss for one cycle only.
    out_ready = 1'b0;
    drive_issue(4'd9);
    step();
    issue_valid = 1'b0;
    drive_commit(4'd7, 1'b0);
    step();
    commit_valid = 1'b0;
    chk("t4_miss_pulse", 128'(commit_miss), 128'd1);
    chk("t4_count_unchanged", 128'(count), 128'd1);
    chk("t4_still_pending", 128'(out_valid), 128'd0);
    step();
    chk("t4_miss_cleared", 128'(commit_miss), 128'd0);
    drive_commit(4'd9, 1'b0);
    step();
    chk("t4_commit_no_miss", 128'(commit_miss), 128'd0);
    // A second commit of id 9 must not retarget the already-committed entry.
    drive_commit(4'd9, 1'b1);
    step();
    commit_valid = 1'b0;
    chk("t4_no_retarget_miss", 128'(commit_miss), 128'd1);
    chk("t4_still_committed", 128'(out_valid), 128'd1);
    push_exp(4'd9);
    out_ready = 1'b1;
    drain("t4_drained");

    // Same-cycle issue and commit of id 5.
    drive_issue(4'd5);
    drive_commit(4'd5, 1'b0);
    push_exp(4'd5);
    step();
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
    chk("t5_out_valid", 128'(out_valid), 128'd1);
    chk("t5_out_id", 128'(out_id), 128'd5);
    chk("t5_no_miss", 128'(commit_miss), 128'd0);
    drain("t5_drained");

    // Stalled committed head stays stable, then an async reset discards it.
    out_ready = 1'b0;
    drive_issue(4'd6);
    drive_commit(4'd6, 1'b0);
    step();
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_stall_valid", 128'(out_valid), 128'd1);
      chk("t6_stall_instr", 128'(out_instr), 128'(instr_of(4'd6)));
      chk("t6_stall_rs", 128'(out_rs), 128'(rs_of(4'd6)));
      chk("t6_stall_mode", 128'(out_mode), 128'(mode_of(4'd6)));
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 128'(out_valid), 128'd0);
    chk("t6_rst_count", 128'(count), 128'd0);
    chk("t6_rst_ready", 128'(issue_ready), 128'd1);
    chk("t6_rst_out_instr", 128'(out_instr), 128'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("t6_after_rst_valid", 128'(out_valid), 128'd0);
    chk("t6_after_rst_count", 128'(count), 128'd0);

    // issue_valid without issue_accept writes nothing.
    drive_issue(4'd10);
    issue_accept = 1'b0;
    step();
    issue_valid  = 1'b0;
    issue_accept = 1'b1;
    chk("t7_not_accepted", 128'(count), 128'd0);
    step();
    chk("t7_out_valid", 128'(out_valid), 128'd0);

    chk("sb_empty", 128'(sb.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
